// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the MEM stage.
// Data accesses win by default. A starvation counter forces a fetch grant after STARVE_MAX losses.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_D  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx;
    logic [CNT_W-1:0]  starve_cnt, starve_cnt_nx;
    logic [DATA_W-1:0] if_rdata_nx, d_rdata_nx;
    logic              if_valid_nx, d_valid_nx;
    logic              mem_en_nx, mem_we_nx, busy_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic              done, arb, if_elig, d_elig, grant_if, grant_d;

    // Stalls follow the request/valid handshake directly.
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

    // Next state and next registered outputs; the completing requester is masked at its own edge.
    always_comb begin
        state_nx      = state;
        wait_cnt_nx   = wait_cnt;
        starve_cnt_nx = starve_cnt;
        if_rdata_nx   = if_rdata;
        d_rdata_nx    = d_rdata;
        if_valid_nx   = 1'b0;
        d_valid_nx    = 1'b0;
        mem_en_nx     = mem_en;
        mem_we_nx     = mem_we;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        busy_nx       = busy;

        done     = (state != IDLE) && (wait_cnt == LAST_WAIT);
        arb      = (state == IDLE) || done;
        if_elig  = if_req && !(done && (state == SERVE_IF));
        d_elig   = d_req && !(done && (state == SERVE_D));
        grant_if = arb && if_elig && (!d_elig || (starve_cnt >= STARVE_LIM));
        grant_d  = arb && d_elig && !grant_if;

        if ((state != IDLE) && !done) begin
            wait_cnt_nx = wait_cnt + CNT_W'(1);
        end

        if (done) begin
            if (state == SERVE_IF) begin
                if_valid_nx = 1'b1;
                if_rdata_nx = mem_rdata;
            end else begin
                d_valid_nx = 1'b1;
                if (!mem_we) begin
                    d_rdata_nx = mem_rdata;
                end
            end
        end

        if (arb) begin
            state_nx     = IDLE;
            wait_cnt_nx  = '0;
            mem_en_nx    = 1'b0;
            mem_we_nx    = 1'b0;
            mem_addr_nx  = '0;
            mem_wdata_nx = '0;
            busy_nx      = 1'b0;
            if (grant_if) begin
                state_nx      = SERVE_IF;
                mem_en_nx     = 1'b1;
                mem_addr_nx   = if_addr;
                busy_nx       = 1'b1;
                starve_cnt_nx = '0;
            end else if (grant_d) begin
                state_nx     = SERVE_D;
                mem_en_nx    = 1'b1;
                mem_we_nx    = d_we;
                mem_addr_nx  = d_addr;
                mem_wdata_nx = d_wdata;
                busy_nx      = 1'b1;
                if (if_elig && (starve_cnt < STARVE_LIM)) begin
                    starve_cnt_nx = starve_cnt + CNT_W'(1);
                end
            end
        end
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_cnt_nx;
            starve_cnt <= starve_cnt_nx;
            if_rdata   <= if_rdata_nx;
            d_rdata    <= d_rdata_nx;
            if_valid   <= if_valid_nx;
            d_valid    <= d_valid_nx;
            mem_en     <= mem_en_nx;
            mem_we     <= mem_we_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            busy       <= busy_nx;
        end
    end

endmodule
